udp_tx_port_arbiter: RTL and testbench

Transmit-side counterpart to the UDP receive port router. It shares one UDP transmit byte path between P_NUM_PORTS local port sources using whole-packet round-robin arbitration. For each granted packet it generates the 8-byte UDP header, then streams the source's payload. Output feeds the IPv4 packet builder through a first-word-fall-through (FWFT) byte interface.

---
 rtl/udp_tx_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_udp_tx_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_port_arbiter.sv
// Whole-packet round-robin arbiter that builds the 8-byte UDP header and then streams the payload.
// Optional per-port completed-packet counters are enabled with `define UDP_TX_ARB_PKT_CNT_EN.
module udp_tx_port_arbiter #(
   parameter int                             P_NUM_PORTS   = 3,
   parameter logic [0:P_NUM_PORTS-1][15:0]   P_PORTS       = {16'd10000, 16'd12000, 16'd14000},
   parameter int                             P_MAX_PAYLOAD = 1472
) (
   input  logic                                i_txmac_clk,
   input  logic                                i_txmac_arst_n,
   input  logic [0:P_NUM_PORTS-1][7:0]         i_port_byte,
   input  logic [0:P_NUM_PORTS-1]              i_port_byte_vld,
   input  logic [0:P_NUM_PORTS-1]              i_port_last_byte,
   input  logic [0:P_NUM_PORTS-1][15:0]        i_port_len,
   input  logic [0:P_NUM_PORTS-1][15:0]        i_port_dest_port,
   output logic [0:P_NUM_PORTS-1]              o_port_byte_rd,
   output logic [7:0]                          o_udp_pkt_byte,
   output logic                                o_udp_pkt_byte_vld,
   output logic                                o_udp_pkt_last_byte,
   input  logic                                i_udp_pkt_byte_rd,
   output logic [$clog2(P_NUM_PORTS)-1:0]      o_grant_idx,
   output logic                                o_busy,
   output logic                                o_len_err,
   output logic [0:P_NUM_PORTS-1][15:0]        o_port_pkt_cnt
);
   localparam int GW = $clog2(P_NUM_PORTS);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_FLUSH} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] ptr_q, ptr_d;
   logic [15:0]   len_q, len_d;
   logic [15:0]   dest_q, dest_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    hdr_cnt_q, hdr_cnt_d;
   logic          len_err_q, len_err_d;

   logic          req_found;
   logic [GW-1:0] req_idx;
   int            cand;
   logic          g_vld, g_last;
   logic [7:0]    g_byte;
   logic [15:0]   src_port, udp_len;
   logic [7:0]    hdr_byte;
   logic          at_end;

   assign g_vld    = i_port_byte_vld[grant_q];
   assign g_last   = i_port_last_byte[grant_q];
   assign g_byte   = i_port_byte[grant_q];
   assign src_port = P_PORTS[grant_q];
   assign udp_len  = len_q + 16'd8;
   assign at_end   = (cnt_q == len_q - 16'd1);

   // Round-robin search starts one past the last grant and wraps.
   always_comb begin
      req_found = 1'b0;
      req_idx   = '0;
      cand      = 0;
      for (int i = 1; i <= P_NUM_PORTS; i++) begin
         cand = (int'(ptr_q) + i) % P_NUM_PORTS;
         if (!req_found && i_port_byte_vld[cand]) begin
            req_found = 1'b1;
            req_idx   = GW'(cand);
         end
      end
   end

   always_comb begin
      hdr_byte = 8'h00;
      case (hdr_cnt_q)
         3'd0:    hdr_byte = src_port[15:8];
         3'd1:    hdr_byte = src_port[7:0];
         3'd2:    hdr_byte = dest_q[15:8];
         3'd3:    hdr_byte = dest_q[7:0];
         3'd4:    hdr_byte = udp_len[15:8];
         3'd5:    hdr_byte = udp_len[7:0];
         default: hdr_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d             = state_q;
      grant_d             = grant_q;
      ptr_d               = ptr_q;
      len_d               = len_q;
      dest_d              = dest_q;
      cnt_d               = cnt_q;
      hdr_cnt_d           = hdr_cnt_q;
      len_err_d           = 1'b0;
      o_port_byte_rd      = '0;
      o_udp_pkt_byte      = 8'h00;
      o_udp_pkt_byte_vld  = 1'b0;
      o_udp_pkt_last_byte = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_found) begin
               grant_d   = req_idx;
               ptr_d     = req_idx;
               len_d     = i_port_len[req_idx];
               dest_d    = i_port_dest_port[req_idx];
               cnt_d     = 16'd0;
               hdr_cnt_d = 3'd0;
               if (i_port_len[req_idx] == 16'd0 || i_port_len[req_idx] > 16'(P_MAX_PAYLOAD)) begin
                  state_d   = S_FLUSH;
                  len_err_d = 1'b1;
               end else begin
                  state_d = S_HDR;
               end
            end
         end
         S_HDR: begin
            o_udp_pkt_byte     = hdr_byte;
            o_udp_pkt_byte_vld = 1'b1;
            if (i_udp_pkt_byte_rd) begin
               hdr_cnt_d = hdr_cnt_q + 3'd1;
               if (hdr_cnt_q == 3'd7) state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            o_udp_pkt_byte              = g_byte;
            o_udp_pkt_byte_vld          = g_vld;
            o_udp_pkt_last_byte         = g_last | at_end;
            o_port_byte_rd[grant_q]     = g_vld & i_udp_pkt_byte_rd;
            if (g_vld && i_udp_pkt_byte_rd) begin
               cnt_d = cnt_q + 16'd1;
               if (g_last) begin
                  state_d   = S_IDLE;
                  len_err_d = !at_end;
               end else if (at_end) begin
                  // Declared length exhausted early: drain the rest of the source packet.
                  state_d   = S_FLUSH;
                  len_err_d = 1'b1;
               end
            end
         end
         S_FLUSH: begin
            o_port_byte_rd[grant_q] = g_vld;
            if (g_vld && g_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_txmac_clk or negedge i_txmac_arst_n) begin
      if (!i_txmac_arst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         ptr_q     <= GW'(P_NUM_PORTS - 1);
         len_q     <= 16'd0;
         dest_q    <= 16'd0;
         cnt_q     <= 16'd0;
         hdr_cnt_q <= 3'd0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         len_q     <= len_d;
         dest_q    <= dest_d;
         cnt_q     <= cnt_d;
         hdr_cnt_q <= hdr_cnt_d;
         len_err_q <= len_err_d;
      end
   end

   assign o_grant_idx = grant_q;
   assign o_busy      = (state_q != S_IDLE);
   assign o_len_err   = len_err_q;

`ifdef UDP_TX_ARB_PKT_CNT_EN
   logic [0:P_NUM_PORTS-1][15:0] pkt_cnt_q, pkt_cnt_d;
   logic                         pkt_done;

   // Counts every packet whose final byte leaves PAYLOAD, length errors included.
   assign pkt_done = (state_q == S_PAYLOAD) && g_vld && i_udp_pkt_byte_rd && (g_last || at_end);

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (pkt_done) pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 16'd1;
   end

   always_ff @(posedge i_txmac_clk or negedge i_txmac_arst_n) begin
      if (!i_txmac_arst_n) pkt_cnt_q <= '0;
      else                 pkt_cnt_q <= pkt_cnt_d;
   end

   assign o_port_pkt_cnt = pkt_cnt_q;
`else
   assign o_port_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_tx_port_arbiter.sv
// Directed bench for udp_tx_port_arbiter: queue-based port sources, output log, immediate assertions.
module tb_udp_tx_port_arbiter;
   localparam int N = 3;
`ifdef UDP_TX_ARB_PKT_CNT_EN
   localparam int EXP_CNT = 3;
`else
   localparam int EXP_CNT = 0;
`endif

   logic                clk = 1'b0;
   logic                rst_n;
   logic [0:N-1][7:0]   pbyte;
   logic [0:N-1]        pvld, plast, prd;
   logic [0:N-1][15:0]  plen, pdest, pcnt;
   logic [7:0]          obyte;
   logic                ovld, olast, ord, busy, lerr;
   logic [1:0]          gnt;

   always #5 clk = ~clk;

   udp_tx_port_arbiter dut (
      .i_txmac_clk(clk), .i_txmac_arst_n(rst_n),
      .i_port_byte(pbyte), .i_port_byte_vld(pvld), .i_port_last_byte(plast),
      .i_port_len(plen), .i_port_dest_port(pdest), .o_port_byte_rd(prd),
      .o_udp_pkt_byte(obyte), .o_udp_pkt_byte_vld(ovld), .o_udp_pkt_last_byte(olast),
      .i_udp_pkt_byte_rd(ord), .o_grant_idx(gnt), .o_busy(busy), .o_len_err(lerr),
      .o_port_pkt_cnt(pcnt));

   int n_chk = 0, n_fail = 0, cyc = 0;
   int n_err, n_vld, n_unstable, n_badrd;
   bit rd_mode, stab;
   logic [7:0] pb;
   logic pl;
   logic [40:0] sq0[$], sq1[$], sq2[$];
   logic [7:0] lg_byte[$];
   logic       lg_last[$];
   int         lg_cyc[$];
   logic [1:0] lg_gnt[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [41:0] front(input int p);
      logic [41:0] e;
      e = '0;
      case (p)
         0: if (sq0.size() > 0) e = {1'b1, sq0[0]};
         1: if (sq1.size() > 0) e = {1'b1, sq1[0]};
         default: if (sq2.size() > 0) e = {1'b1, sq2[0]};
      endcase
      return e;
   endfunction

   task automatic drive();
      logic [41:0] e;
      for (int p = 0; p < N; p++) begin
         e = front(p);
         pvld[p]  = e[41];
         pdest[p] = e[40:25];
         plen[p]  = e[24:9];
         plast[p] = e[8] & e[41];
         pbyte[p] = e[7:0];
      end
   endtask

   task automatic push_pkt(input int p, input logic [15:0] dest, input logic [15:0] len,
                           input int nb, input logic [7:0] base, input logic [7:0] stride);
      logic [40:0] e;
      for (int j = 0; j < nb; j++) begin
         e = {dest, len, (j == nb - 1), 8'(base + stride * 8'(j))};
         case (p)
            0: sq0.push_back(e);
            1: sq1.push_back(e);
            default: sq2.push_back(e);
         endcase
      end
   endtask

   task automatic clear_logs();
      lg_byte.delete(); lg_last.delete(); lg_cyc.delete(); lg_gnt.delete();
      n_err = 0; n_vld = 0; n_unstable = 0; n_badrd = 0; stab = 1'b0;
   endtask

   // One clock: sample settled outputs at negedge, pop sources after posedge.
   task automatic step();
      logic [0:N-1] rd_s;
      @(negedge clk);
      rd_s = prd;
      if (lerr) n_err++;
      if (ovld) n_vld++;
      if ((prd & ~pvld) != '0) n_badrd++;
      if (stab && (obyte !== pb || ovld !== 1'b1 || olast !== pl)) n_unstable++;
      stab = ovld && !ord;
      pb = obyte;
      pl = olast;
      if (ovld && ord) begin
         lg_byte.push_back(obyte);
         lg_last.push_back(olast);
         lg_cyc.push_back(cyc);
         if (olast) lg_gnt.push_back(gnt);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rd_s[0]) void'(sq0.pop_front());
      if (rd_s[1]) void'(sq1.pop_front());
      if (rd_s[2]) void'(sq2.pop_front());
      if (rd_mode) ord = ~ord;
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sq0.delete(); sq1.delete(); sq2.delete();
      drive();
      ord = 1'b1;
      rd_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_logs();
   endtask

   initial begin
      logic [7:0]  e1[12];
      logic [7:0]  e3[16];
      logic [15:0] lv;
      logic [11:0] gv;
      int          gap;

      // Reset state
      rst_n = 1'b0;
      ord = 1'b1;
      sq0.delete();
      drive();
      @(posedge clk);
      #1;
      chk("rst_vld", ovld, 0);
      chk("rst_byte", obyte, 0);
      chk("rst_last", olast, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_lerr", lerr, 0);
      chk("rst_rd", prd, 0);
      chk("rst_cnt", pcnt, 0);

      // T1: single packet on port 0
      do_reset();
      push_pkt(0, 16'd5000, 16'd4, 4, 8'hAA, 8'h11);
      drive();
      repeat (20) step();
      e1 = '{8'h27, 8'h10, 8'h13, 8'h88, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      chk("t1_ntx", lg_byte.size(), 12);
      if (lg_byte.size() == 12) begin
         lv = '0;
         for (int i = 0; i < 12; i++) begin
            chk($sformatf("t1_byte%0d", i), lg_byte[i], e1[i]);
            lv[i] = lg_last[i];
         end
         chk("t1_last", lv, 16'h0800);
         chk("t1_span", lg_cyc[11] - lg_cyc[0], 11);
         chk("t1_gnt", lg_gnt[0], 0);
      end
      chk("t1_lerr", n_err, 0);

      // T2: all three ports requesting, round-robin order
      do_reset();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < N; p++)
            push_pkt(p, 16'(100 + p), 16'd2, 2, 8'(16 * p + 2 * k), 8'd1);
      drive();
      repeat (80) step();
      chk("t2_ntx", lg_byte.size(), 60);
      chk("t2_npkt", lg_gnt.size(), 6);
      if (lg_gnt.size() == 6) begin
         gv = '0;
         for (int i = 0; i < 6; i++) gv = {gv[9:0], lg_gnt[i]};
         chk("t2_order", gv, 12'h186);
      end
      gap = 0;
      for (int i = 1; i < lg_cyc.size(); i++)
         if (lg_cyc[i] - lg_cyc[i-1] > gap) gap = lg_cyc[i] - lg_cyc[i-1];
      chk("t2_maxgap", gap, 2);
      chk("t2_lerr", n_err, 0);

      // T3: downstream rd toggling every cycle
      do_reset();
      push_pkt(1, 16'h1234, 16'd8, 8, 8'h50, 8'd1);
      drive();
      rd_mode = 1'b1;
      repeat (50) step();
      rd_mode = 1'b0;
      ord = 1'b1;
      e3 = '{8'h2E, 8'hE0, 8'h12, 8'h34, 8'h00, 8'h10, 8'h00, 8'h00,
             8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
      chk("t3_ntx", lg_byte.size(), 16);
      if (lg_byte.size() == 16) begin
         lv = '0;
         for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_byte%0d", i), lg_byte[i], e3[i]);
            lv[i] = lg_last[i];
         end
         chk("t3_last", lv, 16'h8000);
         chk("t3_span", lg_cyc[15] - lg_cyc[0], 30);
      end
      chk("t3_stable", n_unstable, 0);
      chk("t3_badrd", n_badrd, 0);

      // T4: early source last, then another request
      do_reset();
      push_pkt(2, 16'd7, 16'd6, 4, 8'h60, 8'd1);
      drive();
      repeat (20) step();
      chk("t4_ntx", lg_byte.size(), 12);
      if (lg_byte.size() == 12) begin
         lv = '0;
         for (int i = 0; i < 12; i++) lv[i] = lg_last[i];
         chk("t4_last", lv, 16'h0800);
         chk("t4_hdrlen", lg_byte[5], 8'h0E);
         chk("t4_byte4", lg_byte[11], 8'h63);
         chk("t4_gnt", lg_gnt[0], 2);
      end
      chk("t4_lerr", n_err, 1);
      push_pkt(0, 16'd9, 16'd1, 1, 8'hEE, 8'd1);
      drive();
      repeat (15) step();
      chk("t4_ntx2", lg_byte.size(), 21);
      if (lg_byte.size() == 21) begin
         chk("t4_b2", lg_byte[20], 8'hEE);
         chk("t4_l2", lg_last[20], 1);
         chk("t4_gnt2", lg_gnt[1], 0);
      end
      chk("t4_lerr2", n_err, 1);

      // T5: oversize and zero-length are flushed silently
      do_reset();
      push_pkt(0, 16'd1, 16'd2000, 3, 8'h70, 8'd1);
      push_pkt(0, 16'd2, 16'd0, 1, 8'h80, 8'd1);
      drive();
      repeat (20) step();
      chk("t5_novld", n_vld, 0);
      chk("t5_popped", sq0.size(), 0);
      chk("t5_lerr", n_err, 2);
      chk("t5_badrd", n_badrd, 0);
      chk("t5_idle", busy, 0);

      // T6: packet counters, then async reset during HDR
      do_reset();
      for (int k = 0; k < 3; k++) push_pkt(1, 16'd50, 16'd1, 1, 8'(8'h90 + k), 8'd1);
      push_pkt(1, 16'd51, 16'd1500, 2, 8'hA0, 8'd1);
      drive();
      repeat (50) step();
      chk("t6_cnt1", pcnt[1], EXP_CNT);
      chk("t6_cnt0", pcnt[0], 0);
      chk("t6_ntx", lg_byte.size(), 27);
      chk("t6_lerr", n_err, 1);
      ord = 1'b0;
      push_pkt(2, 16'd52, 16'd2, 2, 8'hB0, 8'd1);
      drive();
      repeat (3) step();
      @(negedge clk);
      chk("t6_hdr_vld", ovld, 1);
      chk("t6_hdr_busy", busy, 1);
      chk("t6_hdr_gnt", gnt, 2);
      chk("t6_hdr_byte", obyte, 8'h36);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_ar_vld", ovld, 0);
      chk("t6_ar_byte", obyte, 0);
      chk("t6_ar_last", olast, 0);
      chk("t6_ar_busy", busy, 0);
      chk("t6_ar_gnt", gnt, 0);
      chk("t6_ar_lerr", lerr, 0);
      chk("t6_ar_rd", prd, 0);
      chk("t6_ar_cnt", pcnt, 0);
      #10 rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
